noc_reduce_node: RTL and testbench

NOC_REDUCE_NODE -- requirements
Module: noc_reduce_node

---
 rtl/noc_reduce_node.sv | 139 +++++++++++++
 tb/tb_noc_reduce_node.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_reduce_node.sv
// NoC reduction node: folds NUM_OPERANDS operand flits into one result
// flit, emits NUM_RESULTS results, then drains excess operands.
module noc_reduce_node #(
    parameter int TDATAW       = 32,
    parameter int TDESTW       = 4,
    parameter int NUM_OPERANDS = 2,
    parameter int NUM_RESULTS  = 16,
    parameter int OP_MODE      = 0,
    parameter logic [TDESTW-1:0] RESULT_DEST = TDESTW'(3)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic              DONE,
    output logic [15:0]       RESULT_CNT,
    output logic              OVF,
    output logic              ERR
);

    localparam logic [1:0] COLLECT  = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] FINISHED = 2'd2;

    // 9 bits covers the largest legal group of 256 operands
    localparam int CW = 9;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OPERANDS - 1);

    logic [1:0]        state;
    logic [TDATAW-1:0] acc;
    logic [TDATAW-1:0] acc_nxt;
    logic [CW-1:0]     op_cnt;
    logic [15:0]       result_cnt;
    logic              ovf_q;
    logic              err_q;
    logic              ovf_hit;
    logic              s_hs;
    logic              first_op;
    logic              last_op;
    logic              send_st;
    logic [TDATAW:0]   sum;
    logic [31:0]       sent_after;

    // destination of incoming flits carries no meaning for the reduction
    logic unused_tdest;
    assign unused_tdest = ^AXIS_S_TDEST;

    assign send_st  = (state == SEND);
    assign s_hs     = AXIS_S_TVALID && AXIS_S_TREADY;
    assign first_op = (op_cnt == '0);
    assign last_op  = (op_cnt == LAST_IDX);
    assign sum      = {1'b0, acc} + {1'b0, AXIS_S_TDATA};
    assign sent_after = {16'd0, result_cnt} + 32'd1;

    // operand sink is closed during reset and while a result is pending
    assign AXIS_S_TREADY = RST_N && !send_st;
    assign AXIS_M_TVALID = send_st;
    assign AXIS_M_TDATA  = send_st ? acc : '0;
    assign AXIS_M_TLAST  = send_st;
    assign AXIS_M_TDEST  = send_st ? RESULT_DEST : '0;
    assign DONE          = (state == FINISHED);
    assign RESULT_CNT    = result_cnt;
    assign OVF           = ovf_q;
    assign ERR           = err_q;

    // reduction operator; the first operand of a group just loads
    always_comb begin
        acc_nxt = AXIS_S_TDATA;
        ovf_hit = 1'b0;
        if (!first_op) begin
            case (OP_MODE)
                1: begin
                    acc_nxt = sum[TDATAW] ? '1 : sum[TDATAW-1:0];
                    ovf_hit = sum[TDATAW];
                end
                2: begin
                    acc_nxt = (AXIS_S_TDATA > acc) ? AXIS_S_TDATA : acc;
                end
                default: begin
                    acc_nxt = sum[TDATAW-1:0];
                    ovf_hit = sum[TDATAW];
                end
            endcase
        end
    end

    // collect / send / finished sequencing with sticky status flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= COLLECT;
            acc        <= '0;
            op_cnt     <= '0;
            result_cnt <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (s_hs) begin
                        acc <= acc_nxt;
                        if (ovf_hit) ovf_q <= 1'b1;
                        if (AXIS_S_TLAST != last_op) err_q <= 1'b1;
                        if (last_op) begin
                            op_cnt <= '0;
                            state  <= SEND;
                        end else begin
                            op_cnt <= op_cnt + CW'(1);
                        end
                    end
                end
                SEND: begin
                    if (AXIS_M_TREADY) begin
                        if (result_cnt != 16'hFFFF)
                            result_cnt <= result_cnt + 16'd1;
                        if (sent_after >= 32'(NUM_RESULTS))
                            state <= FINISHED;
                        else
                            state <= COLLECT;
                    end
                end
                FINISHED: begin
                    state <= FINISHED;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_reduce_node.sv
// Bench for noc_reduce_node: directed vector table, hand sequences for
// back-pressure / completion / reset, and randomized groups vs a model.
module tb_noc_reduce_node;

    logic        clk;
    logic        rst_n;
    logic        s_valid [5];
    logic        s_last  [5];
    logic        m_ready [5];
    logic [31:0] s_data0;
    logic [7:0]  s_data8 [1:4];
    logic [3:0]  s_dest;
    logic        s_ready [5];
    logic        m_valid [5];
    logic        m_last  [5];
    logic        done    [5];
    logic        ovf     [5];
    logic        err     [5];
    logic [3:0]  m_dest  [5];
    logic [15:0] rcnt    [5];
    logic [31:0] m_data0;
    logic [7:0]  m_data8 [1:4];

    int checks   = 0;
    int failures = 0;
    int rc     [5];
    logic ovf_m[5];
    logic err_m[5];

    noc_reduce_node u0 (
        .CLK(clk), .RST_N(rst_n),
        .AXIS_S_TVALID(s_valid[0]), .AXIS_S_TREADY(s_ready[0]),
        .AXIS_S_TDATA(s_data0), .AXIS_S_TLAST(s_last[0]),
        .AXIS_S_TDEST(s_dest),
        .AXIS_M_TVALID(m_valid[0]), .AXIS_M_TREADY(m_ready[0]),
        .AXIS_M_TDATA(m_data0), .AXIS_M_TLAST(m_last[0]),
        .AXIS_M_TDEST(m_dest[0]),
        .DONE(done[0]), .RESULT_CNT(rcnt[0]),
        .OVF(ovf[0]), .ERR(err[0])
    );

    // 1: add-wrap, 2 results   2: add-sat   3: max of 3   4: pass-through
    for (genvar g = 1; g < 5; g++) begin : g_small
        noc_reduce_node #(
            .TDATAW(8),
            .NUM_OPERANDS(g == 3 ? 3 : (g == 4 ? 1 : 2)),
            .NUM_RESULTS(g == 1 ? 2 : 100),
            .OP_MODE(g == 2 ? 1 : (g == 3 ? 2 : 0))
        ) u (
            .CLK(clk), .RST_N(rst_n),
            .AXIS_S_TVALID(s_valid[g]), .AXIS_S_TREADY(s_ready[g]),
            .AXIS_S_TDATA(s_data8[g]), .AXIS_S_TLAST(s_last[g]),
            .AXIS_S_TDEST(s_dest),
            .AXIS_M_TVALID(m_valid[g]), .AXIS_M_TREADY(m_ready[g]),
            .AXIS_M_TDATA(m_data8[g]), .AXIS_M_TLAST(m_last[g]),
            .AXIS_M_TDEST(m_dest[g]),
            .DONE(done[g]), .RESULT_CNT(rcnt[g]),
            .OVF(ovf[g]), .ERR(err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int nop_of(input int i);
        return (i == 3) ? 3 : ((i == 4) ? 1 : 2);
    endfunction

    function automatic int nr_of(input int i);
        return (i == 0) ? 16 : ((i == 1) ? 2 : 100);
    endfunction

    function automatic int mode_of(input int i);
        return (i == 2) ? 1 : ((i == 3) ? 2 : 0);
    endfunction

    function automatic logic [31:0] mdata(input int i);
        if (i == 0) return m_data0;
        return {24'd0, m_data8[i]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        if (i == 0) s_data0 = d;
        else s_data8[i] = d[7:0];
    endtask

    // present one operand at a negedge and hold it until accepted
    task automatic send_op(input int i, input logic [31:0] d,
                           input logic l);
        int k = 0;
        s_valid[i] = 1'b1;
        s_last[i]  = l;
        set_data(i, d);
        while (!s_ready[i] && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout inst %0d: got waited %0d want <200",
                     i, k);
        end
        @(negedge clk);
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
    endtask

    // wait for a result flit (m_ready assumed high), then pass its handshake
    task automatic get_res(input int i, output logic [31:0] d);
        int k = 0;
        while (!m_valid[i] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("m_valid_seen", {31'd0, m_valid[i]}, 32'd1);
        d = mdata(i);
        chk("m_tlast", {31'd0, m_last[i]}, 32'd1);
        chk("m_tdest", {28'd0, m_dest[i]}, 32'd3);
        @(negedge clk);
    endtask

    task automatic chk_status(input int i);
        chk("result_cnt", {16'd0, rcnt[i]}, 32'(rc[i]));
        chk("ovf", {31'd0, ovf[i]}, {31'd0, ovf_m[i]});
        chk("err", {31'd0, err[i]}, {31'd0, err_m[i]});
        chk("done", {31'd0, done[i]}, {31'd0, rc[i] >= nr_of(i)});
    endtask

    typedef struct {
        int          inst;
        logic [31:0] a;
        logic        la;
        logic [31:0] b;
        logic        lb;
        logic [31:0] res;
        logic        eovf;
        logic        eerr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] r;
        tbl[0] = '{0, 32'd5, 1'b0, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0};
        tbl[1] = '{1, 32'hF0, 1'b0, 32'h20, 1'b1, 32'h10, 1'b1, 1'b0};
        tbl[2] = '{2, 32'hF0, 1'b0, 32'h20, 1'b1, 32'hFF, 1'b1, 1'b0};
        tbl[3] = '{0, 32'd3, 1'b1, 32'd4, 1'b1, 32'd7, 1'b0, 1'b1};
        tbl[4] = '{2, 32'h10, 1'b0, 32'h20, 1'b1, 32'h30, 1'b1, 1'b0};
        tbl[5] = '{0, 32'hFFFFFFFF, 1'b0, 32'd2, 1'b1, 32'd1, 1'b1, 1'b1};

        rst_n   = 1'b0;
        s_dest  = 4'hA;
        s_data0 = '0;
        for (int i = 0; i < 5; i++) begin
            s_valid[i] = 1'b0;
            s_last[i]  = 1'b0;
            m_ready[i] = 1'b1;
            rc[i]      = 0;
            ovf_m[i]   = 1'b0;
            err_m[i]   = 1'b0;
        end
        for (int i = 1; i < 5; i++) s_data8[i] = '0;

        #12;
        for (int i = 0; i < 5; i++) begin
            chk("rst_s_ready", {31'd0, s_ready[i]}, 32'd0);
            chk("rst_m_valid", {31'd0, m_valid[i]}, 32'd0);
            chk("rst_m_data", mdata(i), 32'd0);
            chk("rst_m_last", {31'd0, m_last[i]}, 32'd0);
            chk("rst_m_dest", {28'd0, m_dest[i]}, 32'd0);
            chk_status(i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", {31'd0, s_ready[0]}, 32'd1);
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            send_op(tbl[v].inst, tbl[v].a, tbl[v].la);
            send_op(tbl[v].inst, tbl[v].b, tbl[v].lb);
            get_res(tbl[v].inst, r);
            chk("tbl_result", r, tbl[v].res);
            rc[tbl[v].inst]++;
            ovf_m[tbl[v].inst] = tbl[v].eovf;
            err_m[tbl[v].inst] = tbl[v].eerr;
            chk_status(tbl[v].inst);
        end

        // back-pressure: result held, operand stalled, nothing lost
        send_op(0, 32'd10, 1'b0);
        m_ready[0] = 1'b0;
        send_op(0, 32'd20, 1'b1);
        s_valid[0] = 1'b1;
        s_last[0]  = 1'b0;
        s_data0    = 32'd100;
        for (int c = 0; c < 10; c++) begin
            chk("hold_valid", {31'd0, m_valid[0]}, 32'd1);
            chk("hold_data", m_data0, 32'd30);
            chk("hold_sready", {31'd0, s_ready[0]}, 32'd0);
            @(negedge clk);
        end
        m_ready[0] = 1'b1;
        send_op(0, 32'd100, 1'b0);
        rc[0]++;
        chk_status(0);
        send_op(0, 32'd23, 1'b1);
        get_res(0, r);
        chk("bp_next_sum", r, 32'd123);
        rc[0]++;
        chk_status(0);

        // completion: second result finishes, excess operands drained
        send_op(1, 32'h01, 1'b0);
        send_op(1, 32'h02, 1'b1);
        get_res(1, r);
        chk("fin_result", r, 32'd3);
        rc[1]++;
        chk_status(1);
        for (int e = 0; e < 4; e++) begin
            send_op(1, 32'(8'h40 + e), e[0]);
            chk("fin_no_valid", {31'd0, m_valid[1]}, 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("fin_no_valid_late", {31'd0, m_valid[1]}, 32'd0);
        chk_status(1);

        // reset in the middle of a pending result
        send_op(0, 32'd50, 1'b0);
        m_ready[0] = 1'b0;
        send_op(0, 32'd60, 1'b1);
        chk("pre_rst_valid", {31'd0, m_valid[0]}, 32'd1);
        chk("pre_rst_data", m_data0, 32'd110);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            rc[i]    = 0;
            ovf_m[i] = 1'b0;
            err_m[i] = 1'b0;
        end
        chk("mid_rst_m_valid", {31'd0, m_valid[0]}, 32'd0);
        chk("mid_rst_m_data", m_data0, 32'd0);
        chk("mid_rst_m_last", {31'd0, m_last[0]}, 32'd0);
        chk("mid_rst_m_dest", {28'd0, m_dest[0]}, 32'd0);
        chk("mid_rst_s_ready", {31'd0, s_ready[0]}, 32'd0);
        chk_status(0);
        chk_status(1);
        @(negedge clk);
        rst_n      = 1'b1;
        m_ready[0] = 1'b1;
        #1;
        chk("rel_s_ready", {31'd0, s_ready[0]}, 32'd1);
        send_op(0, 32'd1, 1'b0);
        send_op(0, 32'd2, 1'b1);
        get_res(0, r);
        chk("rel_result", r, 32'd3);
        rc[0]++;
        chk_status(0);

        // randomized groups against an arithmetic model
        for (int i = 2; i < 5; i++) begin
            for (int g = 0; g < 30; g++) begin
                int nop;
                int total;
                int mx;
                int hold;
                int ops[3];
                logic [31:0] exp;
                logic l;
                nop   = nop_of(i);
                total = 0;
                mx    = 0;
                for (int k = 0; k < nop; k++) begin
                    ops[k] = int'($urandom_range(0, 255));
                    total += ops[k];
                    if (ops[k] > mx) mx = ops[k];
                end
                case (mode_of(i))
                    1: begin
                        exp = (total > 255) ? 32'd255 : 32'(total);
                        if (total > 255) ovf_m[i] = 1'b1;
                    end
                    2: exp = 32'(mx);
                    default: begin
                        exp = 32'(total % 256);
                        if (total > 255) ovf_m[i] = 1'b1;
                    end
                endcase
                hold = int'($urandom_range(0, 3));
                for (int k = 0; k < nop; k++) begin
                    l = (k == nop - 1);
                    if ($urandom_range(0, 9) == 0) l = !l;
                    if (l != (k == nop - 1)) err_m[i] = 1'b1;
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    if (k == nop - 1) m_ready[i] = (hold == 0);
                    send_op(i, 32'(ops[k]), l);
                end
                for (int c = 0; c < hold; c++) begin
                    chk("rnd_hold_valid", {31'd0, m_valid[i]}, 32'd1);
                    chk("rnd_hold_data", mdata(i), exp);
                    @(negedge clk);
                end
                m_ready[i] = 1'b1;
                get_res(i, r);
                chk("rnd_result", r, exp);
                rc[i]++;
                chk_status(i);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
